// File: rtl/board_engine_2048.sv
// board_engine_2048
// Game-logic engine for 2048. It owns the 4x4 working board, runs slide/merge
// moves one lane per cycle, drops a pseudo-random 2/4 tile after every move
// that changed something, and tracks score, win and game-over. The board is
// copied to game_state only in CHECK, so the drawer never shows a half move.
//
// Ports:
//   clk         system clock, everything on posedge
//   reset       synchronous active-low reset
//   move_valid  move request, taken only while move_ready is high
//   move_dir    0=up 1=down 2=left 3=right
//   move_ready  idle and the game is still running
//   new_game    clear board and score, spawn two tiles (idle only)
//   load_en     copy load_state into the board, score kept (idle only)
//   load_state  preload board [row][col], row0 top, col0 left
//   game_state  published snapshot, same indexing
//   score       merge score, saturating at 17'h1FFFF
//   game_won    some tile >= WIN_VALUE
//   game_over   no empty cell and no equal orthogonal neighbours
//   busy        ~move_ready
module board_engine_2048 #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          WIN_VALUE = 2048
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   move_valid,
   input  logic [1:0]             move_dir,
   output logic                   move_ready,
   input  logic                   new_game,
   input  logic                   load_en,
   input  logic [3:0][3:0][11:0]  load_state,
   output logic [3:0][3:0][11:0]  game_state,
   output logic [16:0]            score,
   output logic                   game_won,
   output logic                   game_over,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, LANE, SPAWN, CHECK} state_t;

   localparam logic [11:0] WIN_TILE = 12'(WIN_VALUE);

   state_t                  state;
   logic [3:0][3:0][11:0]   board;
   logic [15:0]             lfsr;
   logic [1:0]              dir_q;
   logic [1:0]              lane;
   logic                    changed;
   logic [1:0]              spawn_cnt;
   logic [3:0]              spawn_idx;
   logic [3:0]              scan_cnt;

   logic [3:0][1:0]         row_idx;
   logic [3:0][1:0]         col_idx;
   logic [3:0][11:0]        lane_in;
   logic [3:0][11:0]        lane_out;
   logic [4:0][11:0]        comp;
   logic [12:0]             lane_gain;
   logic                    lane_changed;
   logic [17:0]             score_sum;
   logic [16:0]             score_next;
   logic [11:0]             spawn_cell;
   logic                    won_c;
   logic                    over_c;
   logic                    any_empty;
   logic                    any_pair;

   assign move_ready = (state == IDLE) && !game_won && !game_over;
   assign busy       = ~move_ready;

   // Map lane element k (k=0 is the leading edge the tiles slide toward)
   // onto a board coordinate for the latched direction.
   always_comb begin
      row_idx = '0;
      col_idx = '0;
      for (logic [2:0] k = 3'd0; k < 3'd4; k = k + 3'd1) begin
         case (dir_q)
            2'd0: begin row_idx[k[1:0]] = k[1:0];         col_idx[k[1:0]] = lane;           end
            2'd1: begin row_idx[k[1:0]] = 2'd3 - k[1:0];  col_idx[k[1:0]] = lane;           end
            2'd2: begin row_idx[k[1:0]] = lane;           col_idx[k[1:0]] = k[1:0];         end
            default: begin row_idx[k[1:0]] = lane;        col_idx[k[1:0]] = 2'd3 - k[1:0];  end
         endcase
      end
   end

   // Slide the current lane: first squeeze out the empties, then merge equal
   // neighbours from the leading edge. The skip flag stops a freshly merged
   // tile from merging again, and a tile with bit 11 set cannot double
   // without overflowing 12 bits, so it never merges.
   always_comb begin
      comp      = '0;
      lane_out  = '0;
      lane_gain = '0;
      lane_in   = '0;
      begin : slide
         logic [2:0] n;
         logic [2:0] o;
         logic       skip;
         n    = '0;
         o    = '0;
         skip = 1'b0;
         for (logic [2:0] k = 3'd0; k < 3'd4; k = k + 3'd1) begin
            lane_in[k[1:0]] = board[row_idx[k[1:0]]][col_idx[k[1:0]]];
            if (lane_in[k[1:0]] != 12'd0) begin
               comp[n] = lane_in[k[1:0]];
               n = n + 3'd1;
            end
         end
         for (logic [2:0] k = 3'd0; k < 3'd4; k = k + 3'd1) begin
            if (skip) begin
               skip = 1'b0;
            end else if (comp[k] != 12'd0 && comp[k] == comp[k + 3'd1] && !comp[k][11]) begin
               lane_out[o[1:0]] = {comp[k][10:0], 1'b0};
               lane_gain = lane_gain + {1'b0, comp[k][10:0], 1'b0};
               o = o + 3'd1;
               skip = 1'b1;
            end else begin
               lane_out[o[1:0]] = comp[k];
               o = o + 3'd1;
            end
         end
      end
      lane_changed = (lane_out != lane_in);
   end

   // Saturating score accumulation for the lane being processed.
   always_comb begin
      score_sum  = {1'b0, score} + {5'd0, lane_gain};
      score_next = score_sum[17] ? 17'h1FFFF : score_sum[16:0];
      spawn_cell = board[spawn_idx[3:2]][spawn_idx[1:0]];
   end

   // Win and game-over predicates over the working board, latched in CHECK.
   always_comb begin
      won_c     = 1'b0;
      any_empty = 1'b0;
      any_pair  = 1'b0;
      for (logic [2:0] r = 3'd0; r < 3'd4; r = r + 3'd1) begin
         for (logic [2:0] c = 3'd0; c < 3'd4; c = c + 3'd1) begin
            if (board[r[1:0]][c[1:0]] >= WIN_TILE) won_c = 1'b1;
            if (board[r[1:0]][c[1:0]] == 12'd0)    any_empty = 1'b1;
         end
      end
      for (logic [2:0] r = 3'd0; r < 3'd4; r = r + 3'd1) begin
         for (logic [2:0] c = 3'd0; c < 3'd3; c = c + 3'd1) begin
            if (board[r[1:0]][c[1:0]] == board[r[1:0]][c[1:0] + 2'd1]) any_pair = 1'b1;
         end
      end
      for (logic [2:0] r = 3'd0; r < 3'd3; r = r + 3'd1) begin
         for (logic [2:0] c = 3'd0; c < 3'd4; c = c + 3'd1) begin
            if (board[r[1:0]][c[1:0]] == board[r[1:0] + 2'd1][c[1:0]]) any_pair = 1'b1;
         end
      end
      over_c = !any_empty && !any_pair;
   end

   // Main engine FSM. The LFSR free-runs so the spawn position depends on
   // when the player moves. A spawn scan starts at the LFSR position sampled
   // on entry to SPAWN and walks forward one cell per cycle; a placed tile is
   // non-empty, so the second new-game tile always lands somewhere else.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         board      <= '0;
         game_state <= '0;
         score      <= '0;
         game_won   <= 1'b0;
         game_over  <= 1'b0;
         lfsr       <= LFSR_SEED;
         dir_q      <= '0;
         lane       <= '0;
         changed    <= 1'b0;
         spawn_cnt  <= '0;
         spawn_idx  <= '0;
         scan_cnt   <= '0;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         case (state)
            IDLE: begin
               if (load_en) begin
                  board <= load_state;
                  state <= CHECK;
               end else if (new_game) begin
                  board     <= '0;
                  score     <= '0;
                  spawn_cnt <= 2'd2;
                  spawn_idx <= lfsr[3:0];
                  scan_cnt  <= '0;
                  state     <= SPAWN;
               end else if (move_valid && move_ready) begin
                  dir_q   <= move_dir;
                  lane    <= '0;
                  changed <= 1'b0;
                  state   <= LANE;
               end
            end
            LANE: begin
               for (logic [2:0] k = 3'd0; k < 3'd4; k = k + 3'd1) begin
                  board[row_idx[k[1:0]]][col_idx[k[1:0]]] <= lane_out[k[1:0]];
               end
               score   <= score_next;
               changed <= changed | lane_changed;
               lane    <= lane + 2'd1;
               if (lane == 2'd3) begin
                  if (changed | lane_changed) begin
                     spawn_cnt <= 2'd1;
                     spawn_idx <= lfsr[3:0];
                     scan_cnt  <= '0;
                     state     <= SPAWN;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            SPAWN: begin
               spawn_idx <= spawn_idx + 4'd1;
               if (spawn_cell == 12'd0) begin
                  board[spawn_idx[3:2]][spawn_idx[1:0]] <= (lfsr[6:4] == 3'd0) ? 12'd4 : 12'd2;
                  spawn_cnt <= spawn_cnt - 2'd1;
                  scan_cnt  <= '0;
                  if (spawn_cnt == 2'd1) state <= CHECK;
               end else begin
                  scan_cnt <= scan_cnt + 4'd1;
                  if (scan_cnt == 4'd15) state <= CHECK;
               end
            end
            CHECK: begin
               game_state <= board;
               game_won   <= won_c;
               game_over  <= over_c;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_engine_2048.sv
// tb_board_engine_2048
// Self-checking bench for board_engine_2048: a table of hand-computed moves,
// hand-written sequences for win/new-game/game-over/mid-move reset, and
// random boards checked against a queue-based model of the 2048 slide rules.
module tb_board_engine_2048;

   typedef logic [3:0][3:0][11:0] board_t;

   typedef struct {
      board_t     init;
      logic [1:0] dir;
      board_t     want;
      int         gain;
      bit         changed;
      bit         won;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        move_valid;
   logic [1:0]  move_dir;
   logic        move_ready;
   logic        new_game;
   logic        load_en;
   board_t      load_state;
   board_t      game_state;
   logic [16:0] score;
   logic        game_won;
   logic        game_over;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int exp_score;
   vec_t tbl[6];

   always #5 clk = ~clk;

   board_engine_2048 dut (
      .clk        (clk),
      .reset      (reset),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .move_ready (move_ready),
      .new_game   (new_game),
      .load_en    (load_en),
      .load_state (load_state),
      .game_state (game_state),
      .score      (score),
      .game_won   (game_won),
      .game_over  (game_over),
      .busy       (busy)
   );

   // Build boards one row or column at a time from plain integers.
   function automatic board_t set_row(input board_t b, input int r, input int v0, input int v1, input int v2, input int v3);
      board_t t;
      t = b;
      t[r][0] = 12'(v0); t[r][1] = 12'(v1); t[r][2] = 12'(v2); t[r][3] = 12'(v3);
      return t;
   endfunction

   function automatic board_t set_col(input board_t b, input int c, input int v0, input int v1, input int v2, input int v3);
      board_t t;
      t = b;
      t[0][c] = 12'(v0); t[1][c] = 12'(v1); t[2][c] = 12'(v2); t[3][c] = 12'(v3);
      return t;
   endfunction

   // Position of element k of a lane, counted from the edge tiles slide toward.
   function automatic void cell_rc(input int dir, input int lane, input int k, output int r, output int c);
      case (dir)
         0: begin r = k;     c = lane;  end
         1: begin r = 3 - k; c = lane;  end
         2: begin r = lane;  c = k;     end
         default: begin r = lane; c = 3 - k; end
      endcase
   endfunction

   // 2048 rules on a plain list: gather the non-empty tiles, then walk the
   // list pairing equal neighbours (a pair of 2048s stays apart).
   function automatic void model_move(input board_t b, input int dir, output board_t res, output int gain, output bit changed);
      int q[$];
      int m[$];
      int r, c, i;
      res  = b;
      gain = 0;
      for (int lane = 0; lane < 4; lane++) begin
         q.delete();
         m.delete();
         for (int k = 0; k < 4; k++) begin
            cell_rc(dir, lane, k, r, c);
            if (b[r][c] != 0) q.push_back(int'(b[r][c]));
         end
         i = 0;
         while (i < q.size()) begin
            if (i + 1 < q.size() && q[i] == q[i+1] && q[i] < 2048) begin
               m.push_back(2 * q[i]);
               gain += 2 * q[i];
               i += 2;
            end else begin
               m.push_back(q[i]);
               i += 1;
            end
         end
         for (int k = 0; k < 4; k++) begin
            cell_rc(dir, lane, k, r, c);
            res[r][c] = (k < m.size()) ? 12'(m[k]) : 12'd0;
         end
      end
      changed = (res != b);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic checkBoard(input string name, input board_t actual, input board_t expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   // Compare a post-move snapshot to the pre-spawn board: exactly new_tiles
   // cells may differ, each previously empty and now holding 2 or 4.
   task automatic spawnCheck(input board_t obs, input board_t want, input int new_tiles, input string name);
      int diffs;
      int badcell;
      diffs   = 0;
      badcell = 0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (obs[r][c] !== want[r][c]) begin
               diffs++;
               if (want[r][c] != 0 || !(obs[r][c] == 12'd2 || obs[r][c] == 12'd4)) badcell++;
            end
         end
      end
      checkOutput({name, " new tiles"}, diffs, new_tiles);
      checkOutput({name, " tile legal"}, badcell, 0);
   endtask

   task automatic loadBoard(input board_t b);
      @(negedge clk);
      load_en    = 1'b1;
      load_state = b;
      @(negedge clk);
      load_en = 1'b0;
      @(negedge clk);
      checkBoard("load snapshot", game_state, b);
   endtask

   // Issue one move. For a changing move, lat is the number of clock edges
   // after the accept edge until game_state changes; otherwise it is the
   // number of edges until move_ready returns. Both are bounded at 30.
   task automatic applyStimulus(input logic [1:0] dir, input bit expect_change, output int lat);
      board_t prev;
      @(negedge clk);
      prev       = game_state;
      move_valid = 1'b1;
      move_dir   = dir;
      @(negedge clk);
      move_valid = 1'b0;
      lat = 0;
      while (lat < 30) begin
         @(negedge clk);
         lat++;
         if (expect_change && game_state !== prev) break;
         if (!expect_change && move_ready === 1'b1) break;
      end
   endtask

   task automatic waitChange(output int lat);
      board_t prev;
      prev = game_state;
      lat  = 0;
      while (lat < 30) begin
         @(negedge clk);
         lat++;
         if (game_state !== prev) break;
      end
   endtask

   initial begin
      int     lat;
      board_t b;
      board_t want;
      int     gain;
      bit     chg;
      int     dir;

      reset      = 1'b0;
      move_valid = 1'b0;
      move_dir   = 2'd0;
      new_game   = 1'b0;
      load_en    = 1'b0;
      load_state = '0;

      // Hand-computed moves; the last one creates a 2048 tile.
      tbl[0].init = set_row('0, 0, 2, 2, 2, 2);           tbl[0].dir = 2'd2;
      tbl[0].want = set_row('0, 0, 4, 4, 0, 0);           tbl[0].gain = 8;    tbl[0].changed = 1; tbl[0].won = 0;
      tbl[1].init = set_row('0, 0, 2, 2, 4, 0);           tbl[1].dir = 2'd3;
      tbl[1].want = set_row('0, 0, 0, 0, 4, 4);           tbl[1].gain = 4;    tbl[1].changed = 1; tbl[1].won = 0;
      tbl[2].init = set_col('0, 0, 2, 0, 0, 0);           tbl[2].dir = 2'd0;
      tbl[2].want = set_col('0, 0, 2, 0, 0, 0);           tbl[2].gain = 0;    tbl[2].changed = 0; tbl[2].won = 0;
      tbl[3].init = set_col('0, 1, 4, 0, 4, 8);           tbl[3].dir = 2'd1;
      tbl[3].want = set_col('0, 1, 0, 0, 8, 8);           tbl[3].gain = 8;    tbl[3].changed = 1; tbl[3].won = 0;
      tbl[4].init = set_col('0, 3, 2, 2, 2, 0);           tbl[4].dir = 2'd0;
      tbl[4].want = set_col('0, 3, 4, 2, 0, 0);           tbl[4].gain = 4;    tbl[4].changed = 1; tbl[4].won = 0;
      tbl[5].init = set_row('0, 2, 1024, 1024, 0, 0);     tbl[5].dir = 2'd2;
      tbl[5].want = set_row('0, 2, 2048, 0, 0, 0);        tbl[5].gain = 2048; tbl[5].changed = 1; tbl[5].won = 1;

      // Reset state.
      repeat (2) @(negedge clk);
      checkBoard("reset game_state", game_state, '0);
      checkOutput("reset score", score, 0);
      checkOutput("reset move_ready", move_ready, 1);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset game_won", game_won, 0);
      checkOutput("reset game_over", game_over, 0);
      reset     = 1'b1;
      exp_score = 0;

      // Table-driven moves.
      for (int i = 0; i < 6; i++) begin
         loadBoard(tbl[i].init);
         applyStimulus(tbl[i].dir, tbl[i].changed, lat);
         exp_score += tbl[i].gain;
         if (tbl[i].changed) begin
            checkOutput($sformatf("vec%0d latency in 6..21 (lat=%0d)", i, lat), (lat >= 6 && lat <= 21), 1);
            spawnCheck(game_state, tbl[i].want, 1, $sformatf("vec%0d", i));
         end else begin
            checkOutput($sformatf("vec%0d ready after lanes", i), lat, 4);
            checkBoard($sformatf("vec%0d unchanged", i), game_state, tbl[i].want);
         end
         checkOutput($sformatf("vec%0d score", i), score, exp_score);
         checkOutput($sformatf("vec%0d game_won", i), game_won, tbl[i].won);
      end
      checkOutput("won blocks move_ready", move_ready, 0);

      // New game from the won position.
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      waitChange(lat);
      checkOutput("new_game reached CHECK", lat < 30, 1);
      spawnCheck(game_state, '0, 2, "new_game");
      exp_score = 0;
      checkOutput("new_game score", score, 0);
      checkOutput("new_game game_won", game_won, 0);
      checkOutput("new_game game_over", game_over, 0);
      checkOutput("new_game move_ready", move_ready, 1);

      // Full checkerboard: nothing can move, game over, requests ignored.
      b = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
      loadBoard(b);
      checkOutput("checker game_over", game_over, 1);
      checkOutput("checker move_ready", move_ready, 0);
      checkOutput("checker busy", busy, 1);
      @(negedge clk);
      move_valid = 1'b1;
      move_dir   = 2'd2;
      @(negedge clk);
      move_valid = 1'b0;
      repeat (8) @(negedge clk);
      checkBoard("checker move ignored", game_state, b);
      checkOutput("checker score kept", score, exp_score);

      // Reset in the middle of the lane pass.
      b = set_row('0, 0, 2, 2, 0, 0);
      loadBoard(b);
      @(negedge clk);
      move_valid = 1'b1;
      move_dir   = 2'd2;
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkBoard("midlane reset game_state", game_state, '0);
      checkOutput("midlane reset score", score, 0);
      checkOutput("midlane reset move_ready", move_ready, 1);
      checkOutput("midlane reset busy", busy, 0);
      checkOutput("midlane reset game_over", game_over, 0);
      reset     = 1'b1;
      exp_score = 0;
      repeat (25) @(negedge clk);
      checkBoard("midlane reset no late update", game_state, '0);

      // Random boards against the model.
      for (int it = 0; it < 20; it++) begin
         b = '0;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               int v;
               v = int'($urandom_range(0, 10));
               b[r][c] = (v < 4) ? 12'd0 : 12'(1 << (v - 3));
            end
         end
         b[$urandom_range(0, 3)][$urandom_range(0, 3)] = 12'd0;
         dir = int'($urandom_range(0, 3));
         model_move(b, dir, want, gain, chg);
         loadBoard(b);
         applyStimulus(2'(dir), chg, lat);
         exp_score += gain;
         if (chg) begin
            checkOutput($sformatf("rand%0d latency in 6..21 (lat=%0d)", it, lat), (lat >= 6 && lat <= 21), 1);
            spawnCheck(game_state, want, 1, $sformatf("rand%0d", it));
         end else begin
            checkOutput($sformatf("rand%0d ready after lanes", it), lat, 4);
            checkBoard($sformatf("rand%0d unchanged", it), game_state, want);
         end
         checkOutput($sformatf("rand%0d score", it), score, exp_score);
         checkOutput($sformatf("rand%0d game_won", it), game_won, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_engine_2048.md
Name: board_engine_2048

Overview:
- Game-logic stage directly upstream of the VGA screen drawer.
- Owns the 4x4 board of 12-bit tile values (0 = empty, else 2..2048) and executes slide/merge moves on direction commands.
- Spawns a pseudo-random 2/4 tile after every effective move, and tracks score, win and game-over.
- Publishes the board as a registered snapshot that drives the drawer's game_state input directly.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the spawn LFSR; must be nonzero.
- WIN_VALUE, 2048, tile value that sets game_won.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- move_valid  input  1  move request.
- move_dir  input  2  0=up, 1=down, 2=left, 3=right.
- move_ready  output  1  engine idle and accepting moves.
- new_game  input  1  clears the board and spawns two tiles; sampled only in IDLE.
- load_en  input  1  loads load_state into the board; sampled only in IDLE.
- load_state  input  12x4x4  preload board, indexed [row][col], row0 = top, col0 = left.
- game_state  output  12x4x4  published board snapshot, same indexing.
- score  output  17  accumulated merge score, saturating at 17'h1FFFF.
- game_won  output  1  some tile >= WIN_VALUE.
- game_over  output  1  no empty cell and no equal orthogonal neighbours.
- busy  output  1  equals ~move_ready.

Behaviour:
- Reset (reset==0 at posedge):
  - Working board, game_state and score cleared to 0.
  - game_won = 0, game_over = 0, state = IDLE, move_ready = 1, LFSR = LFSR_SEED.
  - Reset wins over any in-flight operation.
- LFSR: 16-bit Galois, mask 16'hB400, free-runs every cycle.
- FSM states: IDLE, LANE, SPAWN, CHECK.
- IDLE:
  - move_ready = ~(game_won | game_over).
  - Input priority: load_en > new_game > (move_valid & move_ready).
  - load_en: copy load_state into the working board, keep score, go to CHECK.
  - new_game: clear board and score, set spawn_cnt = 2, go to SPAWN.
  - Accepted move: latch move_dir, lane = 0, changed = 0, go to LANE.
- LANE: one lane per cycle, lanes 0..3, so 4 cycles.
  - Lane extraction, leading edge first:
    - up: column c, rows 0..3.
    - down: column c, rows 3..0.
    - left: row r, cols 0..3.
    - right: row r, cols 3..0.
  - Compress nonzeros toward the leading edge.
  - Merge equal adjacent pairs starting from the leading edge; each tile merges at most once per move.
  - Merged value = 2x; score += merged value, saturating.
  - Write the lane back; changed |= (lane differs).
  - After lane 3: if changed, spawn_cnt = 1 and go to SPAWN; else return to IDLE with no spawn, no score change, game_state untouched.
- SPAWN:
  - start = LFSR[3:0]; scan cells idx = start, start+1, ... mod 16 (idx = row*4 + col), one cell per cycle, max 16 cycles.
  - The first empty cell gets 4 if LFSR[6:4]==0, else 2.
  - spawn_cnt decrements per placement; when 0, go to CHECK.
  - If 16 cells are scanned with no empty cell, skip the placement and go to CHECK.
  - The two new_game spawns must land in distinct cells.
- CHECK (1 cycle):
  - game_state <= working board (the only update point, so the display never shows partial moves).
  - game_won <= any tile >= WIN_VALUE.
  - game_over <= no zero cell and no equal horizontal/vertical neighbour pair.
  - Go to IDLE.
- Latency from accepted move to game_state update:
  - 4 LANE cycles + 1..16 SPAWN cycles + 1 CHECK cycle; minimum 6 cycles after the accept edge.
  - load_en: game_state updates 1 cycle after the accept edge.
- Requests arriving outside IDLE are ignored, with no queuing. New_game and load_en also clear game_won and game_over via CHECK.
- Tile values above 2048 are legal up to 12-bit width; 4096 is not representable, so merging two 2048 tiles is suppressed (left unmerged).

Test Plan:
- Reset low 2 cycles -> game_state all 0, score 0, move_ready 1, busy 0, game_won 0, game_over 0.
- load_en with row0 = {2,2,2,2}, rest 0; then left -> row0 = {4,4,x,x} with no merge into 8; score 8; exactly one new tile (2 or 4) placed in a previously empty cell.
- load row0 = {2,2,4,0}, right -> row0 = {0,0,4,4} plus one spawn elsewhere; score 4; 6..21 cycles from accept to game_state change.
- load a full board with no merges, e.g. alternating 2/4 checkerboard -> after CHECK game_over = 1, move_ready = 0; move requests are ignored.
- load column0 = {2,0,0,0} only, move up -> changed = 0, no spawn, game_state unchanged, move_ready back after 4 LANE cycles.
- load a board containing 1024,1024 in row2; left -> game_won = 1, tile 2048 present. Then new_game -> score 0 and exactly two tiles, each 2 or 4, in distinct cells. Assert reset mid-LANE -> full reset state on the next cycle.
